// File: rtl/tff_toggle_conditioner.sv
// Pushbutton conditioner: 2-flop synchroniser plus debounce FSM producing a single-cycle toggle
// request, the debounced level and a wrapping press counter. Optional auto-repeat: TFF_AUTOREPEAT_EN.
module tff_toggle_conditioner #(
  parameter int unsigned DB_CYCLES     = 16,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned REPEAT_DELAY  = 64,
  parameter int unsigned REPEAT_PERIOD = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  input  logic       en,
  output logic       t_pulse,
  output logic       btn_level,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    REL_CHK
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || DB_CYCLES > 65535 || (DB_CYCLES - 1) >= (64'd1 << CNT_W)) begin : g_bad_db
    $error("tff_toggle_conditioner: DB_CYCLES out of range for CNT_W");
  end
  if (REPEAT_DELAY < 1 || REPEAT_DELAY > 65536 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > 65536) begin : g_bad_rpt
    $error("tff_toggle_conditioner: REPEAT_DELAY/REPEAT_PERIOD out of range");
  end

  logic             s1_q;
  logic             s2_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             t_pulse_q;
  logic             level_q;
  logic [7:0]       press_cnt_q;
`ifdef TFF_AUTOREPEAT_EN
  logic [15:0]      rep_q;
  logic             rep_first_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      t_pulse_q   <= 1'b0;
      level_q     <= 1'b0;
      press_cnt_q <= '0;
`ifdef TFF_AUTOREPEAT_EN
      rep_q       <= '0;
      rep_first_q <= 1'b0;
`endif
    end else begin
      s1_q      <= btn_in;
      s2_q      <= s1_q;
      t_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          level_q <= 1'b0;
          if (s2_q) begin
            state_q <= PRESS_CHK;
            cnt_q   <= CNT_W'(1);
          end
        end
        PRESS_CHK: begin
          if (!s2_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= HELD;
            cnt_q       <= '0;
            t_pulse_q   <= en;
            level_q     <= 1'b1;
            press_cnt_q <= press_cnt_q + 8'd1;
`ifdef TFF_AUTOREPEAT_EN
            rep_q       <= '0;
            rep_first_q <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          level_q <= 1'b1;
          if (!s2_q) begin
            state_q <= REL_CHK;
            cnt_q   <= CNT_W'(1);
          end else begin
`ifdef TFF_AUTOREPEAT_EN
            // First repeat waits REPEAT_DELAY HELD cycles, later ones REPEAT_PERIOD.
            if (rep_q == (rep_first_q ? 16'(REPEAT_PERIOD - 1) : 16'(REPEAT_DELAY - 1))) begin
              t_pulse_q   <= en;
              rep_q       <= '0;
              rep_first_q <= 1'b1;
            end else begin
              rep_q <= rep_q + 16'd1;
            end
`endif
          end
        end
        REL_CHK: begin
          if (s2_q) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
`ifdef TFF_AUTOREPEAT_EN
            rep_q       <= '0;
            rep_first_q <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign t_pulse   = t_pulse_q;
  assign btn_level = level_q;
  assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_tff_toggle_conditioner.sv
// Directed bench for tff_toggle_conditioner with DB_CYCLES=4 (acceptance 6 edges after the input edge).
module tb_tff_toggle_conditioner;

  logic       clk;
  logic       rst_n;
  logic       btn_in;
  logic       en;
  logic       t_pulse;
  logic       btn_level;
  logic [7:0] press_cnt;

  int unsigned n_checks;
  int unsigned n_pass;
  int unsigned n_pulse;
  logic [7:0]  exp_cnt;

  tff_toggle_conditioner #(
    .DB_CYCLES    (4),
    .CNT_W        (16),
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_in   (btn_in),
    .en       (en),
    .t_pulse  (t_pulse),
    .btn_level(btn_level),
    .press_cnt(press_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse pattern when held for a long time; k counts edges after btn_in rises.
  function automatic logic exp_hold(input int k);
`ifdef TFF_AUTOREPEAT_EN
    return (k == 6) || (k >= 14 && ((k - 14) % 4) == 0);
`else
    return k == 6;
`endif
  endfunction

  // Full press/release; en switches to en_late after edge en_k (0 = never).
  task automatic press_release(input logic en_start, input logic en_late, input int en_k,
                               input logic exp_pulse);
    en     = en_start;
    btn_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (t_pulse === 1'b1) n_pulse++;
      check("press_pulse", t_pulse, (k == 6) ? exp_pulse : 1'b0);
      check("press_level", btn_level, k >= 6);
      if (k == en_k) en = en_late;
    end
    exp_cnt++;
    check("press_cnt", press_cnt, exp_cnt);
    btn_in = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (t_pulse === 1'b1) n_pulse++;
      check("rel_pulse", t_pulse, 1'b0);
      check("rel_level", btn_level, k < 6);
    end
  endtask

  initial begin
    int unsigned p0;
    logic [7:0]  bounce;
    n_checks = 0;
    n_pass   = 0;
    n_pulse  = 0;
    exp_cnt  = 8'd0;
    rst_n    = 1'b0;
    btn_in   = 1'b0;
    en       = 1'b1;
    tick();
    tick();
    check("rst_pulse", t_pulse, 1'b0);
    check("rst_level", btn_level, 1'b0);
    check("rst_cnt", press_cnt, 8'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Clean press held long: one pulse (or the auto-repeat train).
    btn_in = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      tick();
      check("hold_pulse", t_pulse, exp_hold(k));
      check("hold_level", btn_level, k >= 6);
    end
    exp_cnt++;
    check("hold_cnt", press_cnt, exp_cnt);
    btn_in = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("hold_rel_pulse", t_pulse, 1'b0);
      check("hold_rel_level", btn_level, k < 6);
    end

    // Bounce at low level: runs of 1s shorter than 4 samples.
    bounce = 8'b0110_1110;
    for (int k = 7; k >= 0; k--) begin
      btn_in = bounce[k];
      tick();
      check("bounce_pulse", t_pulse, 1'b0);
      check("bounce_level", btn_level, 1'b0);
    end
    btn_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("bounce_tail_level", btn_level, 1'b0);
    end
    check("bounce_cnt", press_cnt, exp_cnt);

    // Glitch at high level while HELD: three low samples must not release.
    btn_in = 1'b1;
    for (int k = 1; k <= 8; k++) tick();
    exp_cnt++;
    btn_in = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    btn_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("glitch_level", btn_level, 1'b1);
`ifndef TFF_AUTOREPEAT_EN
      check("glitch_pulse", t_pulse, 1'b0);
`endif
    end
    check("glitch_cnt", press_cnt, exp_cnt);
    btn_in = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check("glitch_rel_level", btn_level, 1'b0);

    // en gating and en changes during debounce.
    press_release(1'b0, 1'b0, 0, 1'b0);
    press_release(1'b1, 1'b1, 0, 1'b1);
    press_release(1'b0, 1'b1, 3, 1'b1);
    press_release(1'b1, 1'b0, 5, 1'b0);
    en = 1'b1;

    // Reset in PRESS_CHK with cnt=2, button kept held across reset.
    btn_in = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_pulse", t_pulse, 1'b0);
    check("midrst_level", btn_level, 1'b0);
    check("midrst_cnt", press_cnt, 8'd0);
    tick();
    check("midrst_hold_pulse", t_pulse, 1'b0);
    rst_n   = 1'b1;
    exp_cnt = 8'd0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("postrst_pulse", t_pulse, k == 6);
      check("postrst_level", btn_level, k >= 6);
    end
    exp_cnt++;
    check("postrst_cnt", press_cnt, exp_cnt);
    btn_in = 1'b0;
    for (int k = 0; k < 8; k++) tick();

    // Wrap: 256 presses from a cleared counter.
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    exp_cnt = 8'd0;
    tick();
    p0 = n_pulse;
    for (int i = 0; i < 255; i++) press_release(1'b1, 1'b1, 0, 1'b1);
    check("wrap_cnt_255", press_cnt, 8'd255);
    press_release(1'b1, 1'b1, 0, 1'b1);
    check("wrap_cnt_0", press_cnt, 8'd0);
    check("wrap_pulses", n_pulse - p0, 32'd256);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
